// File: rtl/rx_lane_ctrl_if.sv
// Lane control bundle between the RX lane sequencer and its LP receivers / lane timer.
// The sequencer takes the master modport; the PHY-side environment takes the slave modport.
interface rx_lane_ctrl_if;
  logic [2:0] LpIn;
  logic       Timeout;
  logic       TimerEn;
  logic [2:0] TimerSeed;
  logic       TermEn;
  logic       HsRxEn;
  logic       UlpsActive;
  logic       LpErr;
  logic [2:0] State;

  modport master (
    input  LpIn, Timeout,
    output TimerEn, TimerSeed, TermEn, HsRxEn, UlpsActive, LpErr, State
  );

  modport slave (
    output LpIn, Timeout,
    input  TimerEn, TimerSeed, TermEn, HsRxEn, UlpsActive, LpErr, State
  );
endinterface

// File: rtl/rx_lane_ctrl.sv
// RX lane sequencer: walks LP line codes into HS receive or ULPS, times the
// termination/settle/wake windows through the external lane timer, flags illegal LP codes.
//
// state     | meaning
// STOP      | LP-11 idle
// HS_RQST   | LP-01 seen, HS request
// HS_PREP   | LP-00, waiting termination-enable time
// HS_SETTLE | termination on, waiting HS settle time
// HS_RX     | HS receiver enabled until LP-11
// ESC_RQST  | LP-10 seen, escape request
// ULPS      | ultra-low-power
// WAKE      | LP-10 held for the wake-up time
module rx_lane_ctrl #(
  parameter logic [2:0] SEED_TERMEN = 3'd1,
  parameter logic [2:0] SEED_SETTLE = 3'd2,
  parameter logic [2:0] SEED_WAKE   = 3'd5
) (
  input logic            clk,
  input logic            rst,
  rx_lane_ctrl_if.master lane
);

  typedef enum logic [2:0] {
    ST_STOP      = 3'd0,
    ST_HS_RQST   = 3'd1,
    ST_HS_PREP   = 3'd2,
    ST_HS_SETTLE = 3'd3,
    ST_HS_RX     = 3'd4,
    ST_ESC_RQST  = 3'd5,
    ST_ULPS      = 3'd6,
    ST_WAKE      = 3'd7
  } state_t;

  localparam logic [2:0] LP_000 = 3'b000;
  localparam logic [2:0] LP_001 = 3'b001;
  localparam logic [2:0] LP_100 = 3'b100;
  localparam logic [2:0] LP_111 = 3'b111;

  state_t     state_q, state_d;
  logic       wake_done_q, wake_done_d;
  logic       lp_err_q, lp_err_d;
  logic       timer_en_q, timer_en_d;
  logic [2:0] seed_q, seed_d;
  logic       term_en_q, hs_rx_en_q, ulps_q;
  logic       timed_d, timeout_v;

  // A Timeout seen while the timer is still being armed is stale and ignored.
  assign timeout_v = lane.Timeout & timer_en_q;

  always_comb begin
    state_d     = state_q;
    wake_done_d = wake_done_q;
    lp_err_d    = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (lane.LpIn == LP_001)      state_d = ST_HS_RQST;
        else if (lane.LpIn == LP_100) state_d = ST_ESC_RQST;
        else if (lane.LpIn != LP_111) lp_err_d = 1'b1;
      end
      ST_HS_RQST: begin
        if (lane.LpIn == LP_000)      state_d = ST_HS_PREP;
        else if (lane.LpIn == LP_111) state_d = ST_STOP;
        else if (lane.LpIn != LP_001) begin
          state_d  = ST_STOP;
          lp_err_d = 1'b1;
        end
      end
      ST_HS_PREP: begin
        if (lane.LpIn != LP_000) begin
          state_d  = ST_STOP;
          lp_err_d = 1'b1;
        end else if (timeout_v) begin
          state_d = ST_HS_SETTLE;
        end
      end
      ST_HS_SETTLE: if (timeout_v) state_d = ST_HS_RX;
      ST_HS_RX:     if (lane.LpIn == LP_111) state_d = ST_STOP;
      ST_ESC_RQST: begin
        if (lane.LpIn == LP_000)      state_d = ST_ULPS;
        else if (lane.LpIn == LP_111) state_d = ST_STOP;
        else if (lane.LpIn != LP_100) begin
          state_d  = ST_STOP;
          lp_err_d = 1'b1;
        end
      end
      ST_ULPS: begin
        if (lane.LpIn == LP_100)      state_d = ST_WAKE;
        else if (lane.LpIn != LP_000) lp_err_d = 1'b1;
      end
      ST_WAKE: begin
        if (wake_done_q && lane.LpIn == LP_111) begin
          state_d = ST_STOP;
        end else if (lane.LpIn != LP_100) begin
          state_d  = ST_ULPS;
          lp_err_d = 1'b1;
        end else if (timeout_v) begin
          wake_done_d = 1'b1;
        end
      end
      default: state_d = ST_STOP;
    endcase
    if (state_d != ST_WAKE) wake_done_d = 1'b0;

    timed_d = 1'b0;
    seed_d  = 3'd0;
    case (state_d)
      ST_HS_PREP:   begin timed_d = 1'b1; seed_d = SEED_TERMEN; end
      ST_HS_SETTLE: begin timed_d = 1'b1; seed_d = SEED_SETTLE; end
      ST_WAKE:      begin timed_d = 1'b1; seed_d = SEED_WAKE;   end
      default:      ;
    endcase
    // Entry cycle of a timed state is the arm cycle: enable only while dwelling.
    timer_en_d = timed_d && (state_d == state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STOP;
      wake_done_q <= 1'b0;
      lp_err_q    <= 1'b0;
      timer_en_q  <= 1'b0;
      seed_q      <= 3'd0;
      term_en_q   <= 1'b0;
      hs_rx_en_q  <= 1'b0;
      ulps_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_done_q <= wake_done_d;
      lp_err_q    <= lp_err_d;
      timer_en_q  <= timer_en_d;
      seed_q      <= seed_d;
      term_en_q   <= (state_d == ST_HS_SETTLE) || (state_d == ST_HS_RX);
      hs_rx_en_q  <= (state_d == ST_HS_RX);
      ulps_q      <= (state_d == ST_ULPS) || (state_d == ST_WAKE);
    end
  end

  assign lane.State      = state_q;
  assign lane.LpErr      = lp_err_q;
  assign lane.TimerEn    = timer_en_q;
  assign lane.TimerSeed  = seed_q;
  assign lane.TermEn     = term_en_q;
  assign lane.HsRxEn     = hs_rx_en_q;
  assign lane.UlpsActive = ulps_q;

endmodule

// File: doc/rx_lane_ctrl.md
RX_LANE_CTRL -- requirements
Module: rx_lane_ctrl

Interface
REQ-001 SHALL have parameter SEED_TERMEN, default 3'd1: TimerSeed code for the termination-enable wait.
REQ-002 SHALL have parameter SEED_SETTLE, default 3'd2: TimerSeed code for the HS settle wait.
REQ-003 SHALL have parameter SEED_WAKE, default 3'd5: TimerSeed code for the ULPS wake-up wait.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port LpIn, input, 3 bits: {A,B,C} LP line levels, already synchronised to clk.
REQ-007 SHALL have port Timeout, input, 1 bit: expiry flag from the lane timer.
REQ-008 SHALL have port TimerEn, output, 1 bit: lane timer enable.
REQ-009 SHALL have port TimerSeed, output, 3 bits: lane timer duration select.
REQ-010 SHALL have port TermEn, output, 1 bit: HS termination enable.
REQ-011 SHALL have port HsRxEn, output, 1 bit: HS receiver/data path enable.
REQ-012 SHALL have port UlpsActive, output, 1 bit: lane is in ultra-low-power state.
REQ-013 SHALL have port LpErr, output, 1 bit: one-cycle pulse on an illegal LP sequence.
REQ-014 SHALL have port State, output, 3 bits: current FSM state code.

Function
REQ-015 SHALL implement an FSM with these state codes: STOP=0, HS_RQST=1, HS_PREP=2, HS_SETTLE=3, HS_RX=4, ESC_RQST=5, ULPS=6, WAKE=7.
REQ-016 SHALL register all outputs; each output is consistent with State in the same cycle; a transition takes effect on the edge after the deciding LpIn/Timeout sample.
REQ-017 SHALL apply these STOP transitions: LpIn=001 -> HS_RQST; 100 -> ESC_RQST; 111 -> stay; any other code -> stay, with LpErr pulsed.
REQ-018 SHALL apply these HS_RQST transitions: 001 -> stay; 000 -> HS_PREP; 111 -> STOP; any other code -> STOP, with LpErr pulsed.
REQ-019 SHALL apply these HS_PREP transitions (timed, seed SEED_TERMEN): LpIn must stay 000, otherwise -> STOP with LpErr pulsed; on Timeout -> HS_SETTLE.
REQ-020 SHALL apply these HS_SETTLE transitions (timed, seed SEED_SETTLE, TermEn=1): Timeout -> HS_RX; LpIn is ignored.
REQ-021 SHALL apply these HS_RX transitions (TermEn=1, HsRxEn=1, untimed): LpIn=111 -> STOP; all other codes -> stay.
REQ-022 SHALL apply these ESC_RQST transitions: 100 -> stay; 000 -> ULPS; 111 -> STOP; any other code -> STOP, with LpErr pulsed.
REQ-023 SHALL apply these ULPS transitions (UlpsActive=1): 100 -> WAKE; 000 -> stay; any other code -> stay, with LpErr pulsed.
REQ-024 SHALL apply these WAKE transitions (timed, seed SEED_WAKE, UlpsActive=1): LpIn must stay 100 until Timeout is seen; 111 before Timeout -> ULPS with LpErr pulsed; any other non-100 code -> ULPS with LpErr pulsed.
REQ-025 SHALL, after Timeout has been seen in WAKE, latch "wake done" and then go 111 -> STOP; LpIn=100 -> stay.
REQ-026 SHALL, in any timed state, drive TimerEn=0 in the first cycle after entry (arm cycle) and TimerEn=1 thereafter; TimerSeed SHALL hold the state's seed for the whole dwell, including the arm cycle.
REQ-027 SHALL drive TimerEn=0 and TimerSeed=000 in all untimed states.
REQ-028 SHALL ignore Timeout whenever the TimerEn output is 0.
REQ-029 SHALL give an LpIn violation priority over a simultaneous Timeout.
REQ-030 SHALL, with the team's lane timer, make timed-state dwell equal to N+3 cycles: TERMEN 15 -> 18 cycles, SETTLE 30 -> 33 cycles, WAKE 300 -> 303 cycles minimum.
REQ-031 SHALL drive LpErr high for exactly one cycle per violation, including back-to-back violations in consecutive cycles.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, force State=STOP, TimerEn=0, TimerSeed=000, TermEn=0, HsRxEn=0, UlpsActive=0, LpErr=0, and clear "wake done".
REQ-033 SHALL give rst priority over every LpIn/Timeout event, including mid-HS_RX and mid-WAKE.

Verification
REQ-034 SHALL pass the HS entry scenario: LpIn 111 -> 001 -> 000 held, timer model at defaults -> HS_PREP 18 cycles, TermEn rises on HS_SETTLE entry, HsRxEn rises 33 cycles later.
REQ-035 SHALL pass the HS exit scenario: in HS_RX, LpIn=111 for 1 cycle -> State=STOP, TermEn=0 and HsRxEn=0 on the next edge, LpErr=0.
REQ-036 SHALL pass the aborted HS_PREP scenario: LpIn 000 -> 010 at cycle 5 of HS_PREP -> STOP, LpErr one-cycle pulse, TimerEn=0, TermEn never 1.
REQ-037 SHALL pass the ULPS scenario: 111 -> 100 -> 000 -> UlpsActive=1; then 100 held 310 cycles, then 111 -> STOP, UlpsActive=0; repeat with 111 at cycle 50 of WAKE -> ULPS plus LpErr pulse.
REQ-038 SHALL pass the timeout-ignore scenario: Timeout forced high in STOP and in the arm cycle of HS_PREP -> no state change.
REQ-039 SHALL pass the reset scenario: rst=1 for one cycle during HS_SETTLE -> all outputs at reset values on the next edge; a fresh HS entry afterwards completes with REQ-030 timing.
